pid_loop_filter: RTL and testbench

Parametrised PI/PID loop filter for the GPSDO disciplining loop. It sits between the phase measurement block and the OCXO PWM generator, and runs entirely in the CLK_SYS domain. Each Measure_Done strobe launches a fixed 4-cycle compute sequence: error, integrator update, multiply-accumulate, then clamped duty output. Over the single-register PI block it adds configurable gains and widths, a derivative term, a fractional gain shift, true integrator clamping, output-saturation anti-windup, hold mode, lock qualification and overrun detection.

---
 rtl/pid_loop_filter.sv | 249 ++++++++++++++++++++++++
 tb/tb_pid_loop_filter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pid_loop_filter.sv
`timescale 1ns/1ps
// pid_loop_filter: PI/PID loop filter for the GPSDO disciplining loop.
// Each accepted Measure_Done runs a fixed IDLE->ERR->INT->MAC->OUT sequence
// and turns one phase sample into a clamped OCXO PWM duty word. Also keeps
// lock qualification, integrator anti-windup and overrun reporting.
module pid_loop_filter #(
  parameter int PHASE_W  = 24,
  parameter int ERR_W    = 16,
  parameter int DUTY_W   = 16,
  parameter int ACC_W    = 48,
  parameter int TARGET   = 1_000_000,
  parameter int KP       = 500,
  parameter int KI       = 10,
  parameter int KD       = 0,
  parameter int SHIFT    = 0,
  parameter int ERR_LIM  = 100,
  parameter int INT_LIM  = 100,
  parameter int DUTY_MID = 32768,
  parameter int LOCK_TH  = 20,
  parameter int LOCK_CNT = 8
) (
  input  logic               CLK_SYS,
  input  logic               CLK_RST,
  input  logic [PHASE_W-1:0] Measure_Phase,
  input  logic               Measure_Done,
  input  logic               Hold,
  output logic [DUTY_W-1:0]  PWM_Duty,
  output logic               Duty_Valid,
  output logic [ERR_W-1:0]   Err_Out,
  output logic               Led_Lock,
  output logic               Busy,
  output logic               Overrun
);

  // Error is formed two bits wider than the phase so the subtraction
  // cannot wrap before saturation.
  localparam int EW  = PHASE_W + 2;
  localparam int SW  = ACC_W + 1;
  localparam int LCW = $clog2(LOCK_CNT + 1);

  localparam logic signed [EW-1:0]    TARGET_X   = EW'(TARGET);
  localparam logic signed [EW-1:0]    ERR_MAX_X  = EW'((32'sd1 <<< (ERR_W - 1)) - 32'sd1);
  localparam logic signed [EW-1:0]    ERR_MIN_X  = EW'(-(32'sd1 <<< (ERR_W - 1)));
  localparam logic signed [ACC_W-1:0] LOCK_TH_A  = ACC_W'(LOCK_TH);
  localparam logic signed [ACC_W-1:0] ERR_LIM_A  = ACC_W'(ERR_LIM);
  localparam logic signed [ACC_W-1:0] INT_LIM_A  = ACC_W'(INT_LIM);
  localparam logic signed [ACC_W-1:0] KP_A       = ACC_W'(KP);
  localparam logic signed [ACC_W-1:0] KI_A       = ACC_W'(KI);
  localparam logic signed [ACC_W-1:0] KD_A       = ACC_W'(KD);
  localparam logic signed [SW-1:0]    DUTY_MID_S = SW'(DUTY_MID);
  localparam logic signed [SW-1:0]    DUTY_MAX_S = {{(SW-DUTY_W){1'b0}}, {DUTY_W{1'b1}}};
  localparam logic [DUTY_W-1:0]       DUTY_RST   = DUTY_W'(DUTY_MID);
  localparam logic [LCW-1:0]          LOCK_FULL  = LCW'(LOCK_CNT);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ERR  = 3'd1,
    ST_INT  = 3'd2,
    ST_MAC  = 3'd3,
    ST_OUT  = 3'd4
  } state_t;

  // Saturate the wide phase error into the ERR_W signed range.
  function automatic logic signed [ERR_W-1:0] sat_err(input logic signed [EW-1:0] d);
    logic signed [EW-1:0] r;
    if (d > ERR_MAX_X) begin
      r = ERR_MAX_X;
    end else if (d < ERR_MIN_X) begin
      r = ERR_MIN_X;
    end else begin
      r = d;
    end
    return r[ERR_W-1:0];
  endfunction

  // Sign-extend an error word to the accumulator width.
  function automatic logic signed [ACC_W-1:0] sext_err(input logic signed [ERR_W-1:0] e);
    return {{(ACC_W-ERR_W){e[ERR_W-1]}}, e};
  endfunction

  // Symmetric clamp of the integrator to +/-INT_LIM.
  function automatic logic signed [ACC_W-1:0] clamp_int(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] r;
    if (v > INT_LIM_A) begin
      r = INT_LIM_A;
    end else if (v < -INT_LIM_A) begin
      r = -INT_LIM_A;
    end else begin
      r = v;
    end
    return r;
  endfunction

  state_t                    state_r, state_next_s;
  logic [PHASE_W-1:0]        phase_r;
  logic                      hold_r;
  logic signed [ERR_W-1:0]   err_r, err_prev_r;
  logic signed [ACC_W-1:0]   integ_r, acc_r;
  logic                      sat_hi_r, sat_lo_r;
  logic [LCW-1:0]            lock_cnt_r;
  logic                      led_lock_r;
  logic [DUTY_W-1:0]         duty_r;
  logic                      duty_valid_r, busy_r, overrun_r;

  logic signed [EW-1:0]      diff_s;
  logic signed [ERR_W-1:0]   e_new_s;
  logic signed [ACC_W-1:0]   e_new_x_s, e_x_s, eprev_x_s, int_sum_s, int_clamp_s, mac_s, acc_next_s;
  logic                      lock_hit_s, int_skip_s, e_pos_s, e_neg_s;
  logic [LCW-1:0]            lock_cnt_next_s;
  logic signed [SW-1:0]      sum_s;
  logic [DUTY_W-1:0]         duty_next_s;
  logic                      sat_hi_next_s, sat_lo_next_s;

  // Next-state logic: fixed one-state-per-cycle walk after a strobe.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (Measure_Done) begin
          state_next_s = ST_ERR;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ERR:  state_next_s = ST_INT;
      ST_INT:  state_next_s = ST_MAC;
      ST_MAC:  state_next_s = ST_OUT;
      ST_OUT:  state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Datapath: error/lock, integrator, MAC and duty clamp computed from registers.
  always_comb begin
    diff_s     = {{2{phase_r[PHASE_W-1]}}, phase_r} - TARGET_X;
    e_new_s    = sat_err(diff_s);
    e_new_x_s  = sext_err(e_new_s);
    lock_hit_s = (e_new_x_s <= LOCK_TH_A) && (e_new_x_s >= -LOCK_TH_A);
    lock_cnt_next_s = lock_cnt_r;
    if (!lock_hit_s) begin
      lock_cnt_next_s = {LCW{1'b0}};
    end else if (lock_cnt_r < LOCK_FULL) begin
      lock_cnt_next_s = lock_cnt_r + {{(LCW-1){1'b0}}, 1'b1};
    end else begin
      lock_cnt_next_s = lock_cnt_r;
    end

    // Integration stops while the output is pinned in the same direction.
    e_x_s       = sext_err(err_r);
    e_neg_s     = err_r[ERR_W-1];
    e_pos_s     = !err_r[ERR_W-1] && (err_r != {ERR_W{1'b0}});
    int_sum_s   = integ_r + e_x_s;
    int_clamp_s = clamp_int(int_sum_s);
    int_skip_s  = hold_r || (e_x_s > ERR_LIM_A) || (e_x_s < -ERR_LIM_A) ||
                  (sat_hi_r && e_pos_s) || (sat_lo_r && e_neg_s);

    eprev_x_s  = sext_err(err_prev_r);
    mac_s      = (KP_A * e_x_s) + (KI_A * integ_r) + (KD_A * (e_x_s - eprev_x_s));
    acc_next_s = mac_s >>> SHIFT;

    sum_s         = SW'(acc_r) + DUTY_MID_S;
    duty_next_s   = sum_s[DUTY_W-1:0];
    sat_hi_next_s = 1'b0;
    sat_lo_next_s = 1'b0;
    if (sum_s[SW-1]) begin
      duty_next_s   = {DUTY_W{1'b0}};
      sat_lo_next_s = 1'b1;
    end else if (sum_s > DUTY_MAX_S) begin
      duty_next_s   = {DUTY_W{1'b1}};
      sat_hi_next_s = 1'b1;
    end else begin
      duty_next_s   = sum_s[DUTY_W-1:0];
    end
  end

  // State register.
  always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
    if (!CLK_RST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Per-state register updates plus registered status pulses.
  always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
    if (!CLK_RST) begin
      phase_r      <= {PHASE_W{1'b0}};
      hold_r       <= 1'b0;
      err_r        <= {ERR_W{1'b0}};
      err_prev_r   <= {ERR_W{1'b0}};
      integ_r      <= {ACC_W{1'b0}};
      acc_r        <= {ACC_W{1'b0}};
      sat_hi_r     <= 1'b0;
      sat_lo_r     <= 1'b0;
      lock_cnt_r   <= {LCW{1'b0}};
      led_lock_r   <= 1'b0;
      duty_r       <= DUTY_RST;
      duty_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      duty_valid_r <= 1'b0;
      busy_r       <= (state_next_s != ST_IDLE);
      overrun_r    <= Measure_Done && (state_r != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (Measure_Done) begin
            phase_r <= Measure_Phase;
            hold_r  <= Hold;
          end
        end
        ST_ERR: begin
          err_r      <= e_new_s;
          lock_cnt_r <= lock_cnt_next_s;
          led_lock_r <= (lock_cnt_next_s == LOCK_FULL);
        end
        ST_INT: begin
          if (!int_skip_s) begin
            integ_r <= int_clamp_s;
          end
        end
        ST_MAC: begin
          acc_r      <= acc_next_s;
          err_prev_r <= err_r;
        end
        ST_OUT: begin
          if (!hold_r) begin
            duty_r       <= duty_next_s;
            sat_hi_r     <= sat_hi_next_s;
            sat_lo_r     <= sat_lo_next_s;
            duty_valid_r <= 1'b1;
          end
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign PWM_Duty   = duty_r;
  assign Duty_Valid = duty_valid_r;
  assign Err_Out    = err_r;
  assign Led_Lock   = led_lock_r;
  assign Busy       = busy_r;
  assign Overrun    = overrun_r;

endmodule

// File: tb/tb_pid_loop_filter.sv
`timescale 1ns/1ps
// Self-checking bench for pid_loop_filter: directed scenarios plus random
// samples, compared against a one-shot arithmetic model of each sample.
module tb_pid_loop_filter;

  localparam longint TARGET   = 1_000_000;
  localparam longint KP       = 500;
  localparam longint KI       = 10;
  localparam longint KD       = 0;
  localparam int     SHIFT    = 0;
  localparam longint ERR_LIM  = 100;
  localparam longint INT_LIM  = 100;
  localparam longint DUTY_MID = 32768;
  localparam longint LOCK_TH  = 20;
  localparam longint LOCK_CNT = 8;

  logic        CLK_SYS = 1'b0;
  logic        CLK_RST = 1'b0;
  logic [23:0] Measure_Phase = 24'd0;
  logic        Measure_Done = 1'b0;
  logic        Hold = 1'b0;
  logic [15:0] PWM_Duty;
  logic        Duty_Valid;
  logic [15:0] Err_Out;
  logic        Led_Lock;
  logic        Busy;
  logic        Overrun;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (one-shot per accepted sample).
  longint m_i = 0, m_eprev = 0, m_cnt = 0, m_duty = DUTY_MID, m_e = 0;
  logic   m_hi = 1'b0, m_lo = 1'b0, m_lock = 1'b0;

  pid_loop_filter #(
    .PHASE_W(24), .ERR_W(16), .DUTY_W(16), .ACC_W(48),
    .TARGET(1_000_000), .KP(500), .KI(10), .KD(0), .SHIFT(0),
    .ERR_LIM(100), .INT_LIM(100), .DUTY_MID(32768), .LOCK_TH(20), .LOCK_CNT(8)
  ) dut (
    .CLK_SYS(CLK_SYS), .CLK_RST(CLK_RST),
    .Measure_Phase(Measure_Phase), .Measure_Done(Measure_Done), .Hold(Hold),
    .PWM_Duty(PWM_Duty), .Duty_Valid(Duty_Valid), .Err_Out(Err_Out),
    .Led_Lock(Led_Lock), .Busy(Busy), .Overrun(Overrun)
  );

  always #5 CLK_SYS = ~CLK_SYS;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint clampl(input longint v, input longint lo, input longint hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic model_reset();
    m_i = 0; m_eprev = 0; m_cnt = 0; m_duty = DUTY_MID; m_e = 0;
    m_hi = 1'b0; m_lo = 1'b0; m_lock = 1'b0;
  endtask

  // Whole-sample behaviour straight from the filter equations.
  task automatic model_step(input logic [23:0] ph, input logic hd);
    longint e, acc, sum;
    e = clampl(longint'($signed(ph)) - TARGET, -32768, 32767);
    m_e = e;
    if (e <= LOCK_TH && e >= -LOCK_TH) m_cnt = (m_cnt + 1 > LOCK_CNT) ? LOCK_CNT : m_cnt + 1;
    else m_cnt = 0;
    m_lock = (m_cnt == LOCK_CNT);
    if (!hd && e <= ERR_LIM && e >= -ERR_LIM && !(m_hi && e > 0) && !(m_lo && e < 0))
      m_i = clampl(m_i + e, -INT_LIM, INT_LIM);
    acc = (KP * e + KI * m_i + KD * (e - m_eprev)) >>> SHIFT;
    m_eprev = e;
    if (!hd) begin
      sum = DUTY_MID + acc;
      m_hi = (sum > 65535);
      m_lo = (sum < 0);
      m_duty = clampl(sum, 0, 65535);
    end
  endtask

  // Quiet cycles: nothing should pulse and the block stays idle.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK_SYS); #1;
      chk("idle_valid", Duty_Valid, 0);
      chk("idle_busy", Busy, 0);
      chk("idle_ovr", Overrun, 0);
    end
  endtask

  // One accepted strobe; optionally a second strobe sampled at edge late_k.
  task automatic run_seq(input logic [23:0] ph, input logic hd, input int late_k, input logic [23:0] ph2);
    Measure_Phase = ph; Hold = hd; Measure_Done = 1'b1;
    @(posedge CLK_SYS); #1;
    Measure_Done = 1'b0;
    model_step(ph, hd);
    chk("busy_e0", Busy, 1);
    chk("valid_e0", Duty_Valid, 0);
    for (int k = 1; k <= 4; k++) begin
      if (k == late_k) begin
        Measure_Done = 1'b1; Measure_Phase = ph2; Hold = $urandom_range(0, 1) == 1;
      end
      @(posedge CLK_SYS); #1;
      Measure_Done = 1'b0;
      chk("ovr", Overrun, (k == late_k) ? 1 : 0);
      if (k == 1) begin
        chk("err_out", longint'($signed(Err_Out)), m_e);
        chk("led_lock", Led_Lock, m_lock);
      end
      if (k < 4) begin
        chk("busy", Busy, 1);
        chk("valid_early", Duty_Valid, 0);
      end else begin
        chk("busy_done", Busy, 0);
        chk("valid", Duty_Valid, hd ? 0 : 1);
        chk("duty", PWM_Duty, m_duty);
      end
    end
  endtask

  initial begin
    int off;
    logic [23:0] ph;
    logic hd;
    int lk;

    // Reset state
    repeat (3) @(posedge CLK_SYS);
    #1;
    chk("rst_duty", PWM_Duty, 32768);
    chk("rst_busy", Busy, 0);
    CLK_RST = 1'b1;
    chk("rst_err", longint'($signed(Err_Out)), 0);
    chk("rst_lock", Led_Lock, 0);
    idle(20);

    // Two samples at e=10, ten cycles apart
    run_seq(24'd1_000_010, 1'b0, 0, 24'd0);
    chk("first_duty_abs", PWM_Duty, 37868);
    idle(5);
    run_seq(24'd1_000_010, 1'b0, 0, 24'd0);
    chk("second_duty_abs", PWM_Duty, 37968);
    idle(5);

    // Integrator clamp, high saturation, anti-windup, low saturation, hold
    repeat (12) begin
      run_seq(24'd1_000_010, 1'b0, 0, 24'd0);
      idle(1);
    end
    run_seq(24'd1_000_200, 1'b0, 0, 24'd0);
    chk("sat_hi_duty", PWM_Duty, 65535);
    idle(1);
    run_seq(24'd1_000_005, 1'b0, 0, 24'd0);
    chk("windup_duty", PWM_Duty, 36268);
    idle(1);
    run_seq(24'd0, 1'b0, 0, 24'd0);
    chk("neg_sat_err", longint'($signed(Err_Out)), -32768);
    chk("low_duty", PWM_Duty, 0);
    idle(1);
    run_seq(24'd1_000_000, 1'b1, 0, 24'd0);
    chk("hold_duty", PWM_Duty, 0);
    idle(2);

    // Lock qualification: clear, eight in-window samples, then one outside
    run_seq(24'd1_000_030, 1'b0, 0, 24'd0);
    repeat (8) begin
      run_seq(24'd1_000_005, 1'b0, 0, 24'd0);
      idle(1);
    end
    chk("lock_set", Led_Lock, 1);
    run_seq(24'd1_000_030, 1'b0, 0, 24'd0);
    chk("lock_clr", Led_Lock, 0);
    idle(2);

    // Overrun: strobe 2 cycles in; strobe at OUT dropped, one later accepted
    run_seq(24'd1_000_003, 1'b0, 2, 24'd999_000);
    idle(2);
    run_seq(24'd1_000_004, 1'b0, 4, 24'd1_000_090);
    run_seq(24'd1_000_050, 1'b0, 0, 24'd0);
    idle(2);

    // Randomized samples
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 7) == 0) ph = 24'($urandom);
      else begin
        off = int'($urandom_range(0, 600)) - 300;
        ph = 24'(1_000_000 + off);
      end
      hd = ($urandom_range(0, 7) == 0);
      lk = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 4)) : 0;
      run_seq(ph, hd, lk, 24'($urandom));
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
    end
    idle(2);

    // Reset asserted while the sequence sits in MAC
    Measure_Phase = 24'd1_000_010; Hold = 1'b0; Measure_Done = 1'b1;
    @(posedge CLK_SYS); #1;
    Measure_Done = 1'b0;
    @(posedge CLK_SYS); #1;
    @(posedge CLK_SYS); #1;
    CLK_RST = 1'b0;
    #1;
    chk("mrst_duty", PWM_Duty, 32768);
    chk("mrst_valid", Duty_Valid, 0);
    chk("mrst_err", longint'($signed(Err_Out)), 0);
    chk("mrst_busy", Busy, 0);
    chk("mrst_lock", Led_Lock, 0);
    @(posedge CLK_SYS); #1;
    chk("mrst_valid2", Duty_Valid, 0);
    CLK_RST = 1'b1;
    model_reset();
    idle(8);
    chk("post_rst_duty", PWM_Duty, 32768);
    run_seq(24'd1_000_010, 1'b0, 0, 24'd0);
    chk("post_rst_abs", PWM_Duty, 37868);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
